// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: reset/bubble defaults, opcodes used by
// decode, the fetch FSM encoding and a PC alignment helper.
package rv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel between fetch and the memory.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Front pipeline stage: owns the PC, keeps one imem request in flight and
// feeds the IF/ID register, with a single-entry skid buffer for decode stalls.
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  instruction_fetch_if.master        imem,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  output logic                       instr_valid
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_pc_r, req_pc_s;
  logic         discard_r, discard_s;
  logic [31:0]  instr_r, instr_s;
  logic [31:0]  instr_pc_r, instr_pc_s;
  logic         instr_valid_r, instr_valid_s;
  logic [31:0]  skid_data_r, skid_data_s;
  logic [31:0]  skid_pc_r, skid_pc_s;
  logic         skid_valid_r, skid_valid_s;
  logic         handshake_s;
  logic         slot_free_s;

  assign imem.imem_req  = (state_r == REQ);
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign instr_pc       = instr_pc_r;
  assign instr_valid    = instr_valid_r;

  // Next-state computation for the FSM, PC, IF/ID register and skid buffer.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    req_pc_s      = req_pc_r;
    discard_s     = discard_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    skid_data_s   = skid_data_r;
    skid_pc_s     = skid_pc_r;
    skid_valid_s  = skid_valid_r;
    handshake_s   = (state_r == REQ) && imem.imem_ready;
    slot_free_s   = !stall || !instr_valid_r;

    // Without a new word, decode consuming the slot leaves a bubble behind.
    if (!stall) begin
      instr_valid_s = 1'b0;
      instr_s       = NOP_INSTR;
    end else begin
      instr_valid_s = instr_valid_r;
      instr_s       = instr_r;
    end

    if (redirect_valid) begin
      pc_s          = align_pc(redirect_pc);
      instr_valid_s = 1'b0;
      instr_s       = NOP_INSTR;
      skid_valid_s  = 1'b0;
      if (handshake_s || ((state_r == WAIT) && !imem.imem_rsp_valid)) begin
        discard_s = 1'b1;
        state_s   = WAIT;
      end else begin
        discard_s = (imem.imem_rsp_valid && (state_r != HOLD)) ? 1'b0 : discard_r;
        state_s   = REQ;
      end
    end else begin
      case (state_r)
        REQ: begin
          // A stale pre-reset response landing here retires the discard.
          if (imem.imem_rsp_valid) begin
            discard_s = 1'b0;
          end else begin
            discard_s = discard_r;
          end
          if (handshake_s) begin
            req_pc_s = pc_r;
            pc_s     = pc_r + 32'd4;
            state_s  = WAIT;
          end else begin
            state_s  = REQ;
          end
        end
        WAIT: begin
          if (!imem.imem_rsp_valid) begin
            state_s = WAIT;
          end else if (discard_r) begin
            discard_s = 1'b0;
            state_s   = REQ;
          end else if (slot_free_s) begin
            instr_s       = imem.imem_rsp_data;
            instr_pc_s    = req_pc_r;
            instr_valid_s = 1'b1;
            state_s       = REQ;
          end else begin
            skid_data_s  = imem.imem_rsp_data;
            skid_pc_s    = req_pc_r;
            skid_valid_s = 1'b1;
            state_s      = HOLD;
          end
        end
        HOLD: begin
          if (!skid_valid_r) begin
            state_s = REQ;
          end else if (!stall) begin
            instr_s       = skid_data_r;
            instr_pc_s    = skid_pc_r;
            instr_valid_s = 1'b1;
            skid_valid_s  = 1'b0;
            state_s       = REQ;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = REQ;
        end
      endcase
    end
  end

  // State registers with synchronous reset; a reset during WAIT arms discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= REQ;
      pc_r          <= RESET_PC;
      req_pc_r      <= 32'h0000_0000;
      discard_r     <= (state_r == WAIT);
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      skid_data_r   <= 32'h0000_0000;
      skid_pc_r     <= 32'h0000_0000;
      skid_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      req_pc_r      <= req_pc_s;
      discard_r     <= discard_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      skid_data_r   <= skid_data_s;
      skid_pc_r     <= skid_pc_s;
      skid_valid_r  <= skid_valid_s;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  instruction_fetch_if imem();

  instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit mem_ready_en = 1'b0;
  int mem_lat = 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: one outstanding request, response mem_lat cycles after accept.
  initial begin
    bit          hs_seen;
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    hs_seen = 1'b0; pend = 1'b0; cnt = 0; pend_addr = 32'h0;
    imem.imem_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (hs_seen) begin
        pend = 1'b1;
        cnt  = mem_lat - 1;
      end
      if (pend && cnt == 0) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = word_of(pend_addr);
        pend = 1'b0;
      end else begin
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        if (pend) cnt = cnt - 1;
      end
      imem.imem_ready = mem_ready_en;
      #1;
      hs_seen = imem.imem_req && imem.imem_ready;
      if (hs_seen) pend_addr = imem.imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_ready_en = 1'b0; mem_lat = 1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; mem_ready_en = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (imem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req got %0h want 1", imem.imem_req); end
    tests_run++; if (imem.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %08h want 00000000", imem.imem_addr); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0h want 0", instr_valid); end
    tests_run++; if (instr !== NOP) begin tests_failed++; $display("FAIL reset_instr got %08h want %08h", instr, NOP); end
    tests_run++; if (instr_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_pc got %08h want 00000000", instr_pc); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset();
    mem_ready_en = 1'b1; mem_lat = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_v  = (k >= 2) && (k % 2 == 0);
      exp_pc = 32'(((k / 2) - 1) * 4);
      tests_run++; if (instr_valid !== exp_v) begin tests_failed++; $display("FAIL seq_valid cyc%0d got %0h want %0h", k, instr_valid, exp_v); end
      if (exp_v) begin
        tests_run++; if (instr_pc !== exp_pc) begin tests_failed++; $display("FAIL seq_pc cyc%0d got %08h want %08h", k, instr_pc, exp_pc); end
        tests_run++; if (instr !== word_of(exp_pc)) begin tests_failed++; $display("FAIL seq_instr cyc%0d got %08h want %08h", k, instr, word_of(exp_pc)); end
      end else begin
        tests_run++; if (instr !== NOP) begin tests_failed++; $display("FAIL seq_bubble cyc%0d got %08h want %08h", k, instr, NOP); end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    mem_ready_en = 1'b1; mem_lat = 1;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
        tests_failed++; $display("FAIL stall_hold cyc%0d got v=%0h pc=%08h i=%08h want v=1 pc=00000000", k, instr_valid, instr_pc, instr); end
      if (k == 4) begin
        tests_run++; if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_hold_noreq got %0h want 0", imem.imem_req); end
      end
    end
    stall = 1'b0;
    @(negedge clk);
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== word_of(32'h4)) begin
      tests_failed++; $display("FAIL stall_release got v=%0h pc=%08h want v=1 pc=00000004", instr_valid, instr_pc); end
    @(negedge clk);
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_gap got %0h want 0", instr_valid); end
    @(negedge clk);
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
      tests_failed++; $display("FAIL stall_next got v=%0h pc=%08h want v=1 pc=00000008", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    mem_ready_en = 1'b1; mem_lat = 2;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++; if (instr_valid !== 1'b0 || imem.imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL redir_wait_state got v=%0h req=%0h want v=0 req=0", instr_valid, imem.imem_req); end
    @(negedge clk);
    tests_run++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL redir_addr got req=%0h addr=%08h want req=1 addr=00000100", imem.imem_req, imem.imem_addr); end
    wait_valid(12, ok);
    tests_run++; if (!ok || instr_pc !== 32'h100 || instr !== word_of(32'h100)) begin
      tests_failed++; $display("FAIL redir_first got ok=%0d pc=%08h i=%08h want pc=00000100", ok, instr_pc, instr); end
  endtask

  task automatic test_redirect_stall();
    bit ok;
    do_reset();
    mem_ready_en = 1'b1; mem_lat = 1;
    repeat (2) @(negedge clk);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    tests_run++; if (instr_valid !== 1'b0 || instr !== NOP) begin
      tests_failed++; $display("FAIL redir_stall_flush got v=%0h i=%08h want v=0 i=%08h", instr_valid, instr, NOP); end
    @(negedge clk);
    tests_run++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200) begin
      tests_failed++; $display("FAIL redir_stall_addr got req=%0h addr=%08h want req=1 addr=00000200", imem.imem_req, imem.imem_addr); end
    wait_valid(12, ok);
    tests_run++; if (!ok || instr_pc !== 32'h200 || instr !== word_of(32'h200)) begin
      tests_failed++; $display("FAIL redir_stall_first got ok=%0d pc=%08h want pc=00000200", ok, instr_pc); end
  endtask

  task automatic test_backpressure_wrap();
    bit ok;
    do_reset();
    mem_lat = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests_run++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
        tests_failed++; $display("FAIL bp_stable cyc%0d got req=%0h addr=%08h want req=1 addr=00000000", k, imem.imem_req, imem.imem_addr); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; mem_ready_en = 1'b1;
    tests_run++; if (imem.imem_addr !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_addr got %08h want fffffffc", imem.imem_addr); end
    wait_valid(12, ok);
    tests_run++; if (!ok || instr_pc !== 32'hFFFF_FFFC || instr !== word_of(32'hFFFF_FFFC)) begin
      tests_failed++; $display("FAIL wrap_first got ok=%0d pc=%08h want pc=fffffffc", ok, instr_pc); end
    tests_run++; if (imem.imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_next_addr got %08h want 00000000", imem.imem_addr); end
    wait_valid(12, ok);
    tests_run++; if (!ok || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
      tests_failed++; $display("FAIL wrap_second got ok=%0d pc=%08h want pc=00000000", ok, instr_pc); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0; mem_lat = 3; mem_ready_en = 1'b1;
    @(negedge clk);
    reset = 1'b1; mem_ready_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL rst_wait_state got v=%0h req=%0h addr=%08h want v=0 req=1 addr=00000000", instr_valid, imem.imem_req, imem.imem_addr); end
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_stale got %0h want 0", instr_valid); end
    mem_ready_en = 1'b1;
    wait_valid(16, ok);
    tests_run++; if (!ok || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
      tests_failed++; $display("FAIL rst_wait_first got ok=%0d pc=%08h i=%08h want pc=00000000 i=%08h", ok, instr_pc, instr, word_of(32'h0)); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall();
    test_backpressure_wrap();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
